// File: rtl/uart_seg_cmd_ctrl_if.sv
// rtl/uart_seg_cmd_ctrl_if.sv - receiver byte stream in, display registers and frame status out
interface uart_seg_cmd_ctrl_if;
    logic        i_RX_DV;
    logic [7:0]  i_RX_Byte;
    logic [15:0] o_Digits;
    logic [3:0]  o_Dp;
    logic [3:0]  o_Digit_En;
    logic        o_Frame_OK;
    logic        o_Frame_Err;
    logic [7:0]  o_Err_Count;

    modport master (
        output i_RX_DV, i_RX_Byte,
        input  o_Digits, o_Dp, o_Digit_En, o_Frame_OK, o_Frame_Err, o_Err_Count
    );

    modport slave (
        input  i_RX_DV, i_RX_Byte,
        output o_Digits, o_Dp, o_Digit_En, o_Frame_OK, o_Frame_Err, o_Err_Count
    );
endinterface

// File: rtl/uart_seg_cmd_ctrl.sv
// rtl/uart_seg_cmd_ctrl.sv - 4-byte command frame parser driving 7-segment display registers
module uart_seg_cmd_ctrl #(
    parameter int         TIMEOUT_CLKS = 8760,
    parameter logic [7:0] SOF_BYTE     = 8'hA5
) (
    input  logic                i_Clock,
    input  logic                i_Rst_n,
    uart_seg_cmd_ctrl_if.slave  bus
);

    localparam int CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_GET_CHK,
        S_COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        good_q, good_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  en_q, en_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [7:0]  errcnt_q, errcnt_d;
    logic        reject;
    logic        addr_valid;

    assign addr_valid = (addr_q[7:2] == 6'd0) || (addr_q == 8'h10) || (addr_q == 8'h11);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            good_q   <= 1'b0;
            digits_q <= 16'h0000;
            dp_q     <= 4'h0;
            en_q     <= 4'hF;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            good_q   <= good_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            en_q     <= en_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        good_d   = good_q;
        digits_d = digits_q;
        dp_d     = dp_q;
        en_d     = en_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        errcnt_d = errcnt_q;
        reject   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.i_RX_DV && (bus.i_RX_Byte == SOF_BYTE)) begin
                    state_d = S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                if (bus.i_RX_DV) begin
                    addr_d  = bus.i_RX_Byte;
                    cnt_d   = '0;
                    state_d = S_GET_DATA;
                end else if (cnt_q == TERM) begin
                    cnt_d   = '0;
                    reject  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GET_DATA: begin
                if (bus.i_RX_DV) begin
                    data_d  = bus.i_RX_Byte;
                    cnt_d   = '0;
                    state_d = S_GET_CHK;
                end else if (cnt_q == TERM) begin
                    cnt_d   = '0;
                    reject  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GET_CHK: begin
                if (bus.i_RX_DV) begin
                    good_d  = (bus.i_RX_Byte == (addr_q ^ data_q)) && addr_valid;
                    cnt_d   = '0;
                    state_d = S_COMMIT;
                end else if (cnt_q == TERM) begin
                    cnt_d   = '0;
                    reject  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COMMIT: begin
                cnt_d = '0;
                if (good_q) begin
                    ok_d = 1'b1;
                    if (addr_q[7:2] == 6'd0) begin
                        digits_d[{addr_q[1:0], 2'b00} +: 4] = data_q[3:0];
                        dp_d[addr_q[1:0]] = data_q[7];
                    end else if (addr_q == 8'h10) begin
                        en_d = data_q[3:0];
                    end else begin
                        digits_d = 16'h0000;
                        dp_d     = 4'h0;
                    end
                end else begin
                    reject = 1'b1;
                end
                // A byte arriving during the commit cycle is parsed as if already idle.
                if (bus.i_RX_DV && (bus.i_RX_Byte == SOF_BYTE)) begin
                    state_d = S_GET_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (reject) begin
            err_d = 1'b1;
            if (errcnt_q != 8'hFF) begin
                errcnt_d = errcnt_q + 8'h01;
            end
        end
    end

    assign bus.o_Digits    = digits_q;
    assign bus.o_Dp        = dp_q;
    assign bus.o_Digit_En  = en_q;
    assign bus.o_Frame_OK  = ok_q;
    assign bus.o_Frame_Err = err_q;
    assign bus.o_Err_Count = errcnt_q;

endmodule

// File: tb/tb_uart_seg_cmd_ctrl.sv
// tb/tb_uart_seg_cmd_ctrl.sv - randomized frame stimulus against a frame-level reference model
module tb_uart_seg_cmd_ctrl;

    localparam int         T   = 40;
    localparam logic [7:0] SOF = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_seg_cmd_ctrl_if bus();

    uart_seg_cmd_ctrl #(.TIMEOUT_CLKS(T), .SOF_BYTE(SOF)) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: position within frame, collected bytes, resulting registers.
    logic [3:0] m_dig [4];
    logic [3:0] m_dp, m_en;
    int         m_rej, m_ok_n, m_err_n, m_pos;
    logic [7:0] m_addr, m_data;
    int         ok_seen = 0;
    int         err_seen = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_dp = 4'h0; m_en = 4'hF; m_rej = 0; m_pos = 0;
    endtask

    task automatic model_reject();
        m_rej++; m_err_n++;
    endtask

    task automatic model_commit(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        int ai;
        ai = int'(a);
        if (c != (a ^ d) || !(ai <= 3 || ai == 16 || ai == 17)) begin
            model_reject();
        end else begin
            m_ok_n++;
            if (ai <= 3) begin
                m_dig[ai] = d[3:0];
                m_dp[ai]  = d[7];
            end else if (ai == 16) begin
                m_en = d[3:0];
            end else begin
                for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
                m_dp = 4'h0;
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int gap);
        if (m_pos != 0 && gap >= T) begin
            model_reject();
            m_pos = 0;
        end
        case (m_pos)
            0: if (b == SOF) m_pos = 1;
            1: begin m_addr = b; m_pos = 2; end
            2: begin m_data = b; m_pos = 3; end
            default: begin model_commit(m_addr, m_data, b); m_pos = 0; end
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_RX_DV = 1'b1; bus.i_RX_Byte = b;
        @(posedge clk); #1;
        bus.i_RX_DV = 1'b0;
    endtask

    task automatic tx(input logic [7:0] b, input int gap);
        model_byte(b, gap);
        idle(gap);
        send(b);
    endtask

    task automatic tx_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        tx(SOF, 0); tx(a, 0); tx(d, 0); tx(c, 0);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_digits"}, bus.o_Digits, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
        check({tag, "_dp"}, bus.o_Dp, m_dp);
        check({tag, "_en"}, bus.o_Digit_En, m_en);
        check({tag, "_errcnt"}, bus.o_Err_Count, (m_rej > 255) ? 255 : m_rej);
        check({tag, "_okpulses"}, ok_seen, m_ok_n);
        check({tag, "_errpulses"}, err_seen, m_err_n);
    endtask

    task automatic settle(input string tag);
        idle(T + 3);
        if (m_pos != 0) begin
            model_reject();
            m_pos = 0;
        end
        check_all(tag);
    endtask

    always @(negedge clk) begin
        if (bus.o_Frame_OK) ok_seen++;
        if (bus.o_Frame_Err) err_seen++;
        if (bus.o_Frame_OK || bus.o_Frame_Err)
            check("ok_err_excl", 32'(bus.o_Frame_OK && bus.o_Frame_Err), 0);
    end

    function automatic int rand_gap();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return $urandom_range(0, 2);
        if (r == 7) return T - 1;
        if (r == 8) return T;
        return 0;
    endfunction

    initial begin
        logic [7:0] a, d, c;
        logic [7:0] addrs [6];
        addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11};
        m_ok_n = 0; m_err_n = 0;
        model_reset();
        bus.i_RX_DV = 1'b0; bus.i_RX_Byte = 8'h00;

        #12;
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Commit latency: nothing visible right after the CHK edge, all of it one edge later.
        tx(SOF, 0); tx(8'h02, 0); tx(8'h07, 0);
        model_byte(8'h05, 0);
        send(8'h05);
        check("t1_e_ok", bus.o_Frame_OK, 0);
        check("t1_e_dig2", bus.o_Digits[11:8], 0);
        idle(1);
        check("t1_e1_ok", bus.o_Frame_OK, 1);
        check("t1_e1_dig2", bus.o_Digits[11:8], 7);
        check("t1_e1_dp2", bus.o_Dp[2], 0);
        idle(1);
        check("t1_e2_ok", bus.o_Frame_OK, 0);
        settle("t1");

        tx_frame(8'h01, 8'h8C, 8'h8D);
        tx_frame(8'h10, 8'h05, 8'h15);
        settle("t2");
        check("t2_en", bus.o_Digit_En, 4'b0101);
        check("t2_dig1", bus.o_Digits[7:4], 4'hC);

        tx_frame(8'h03, 8'h04, 8'h00);
        tx_frame(8'h20, 8'h01, 8'h21);
        settle("t3");
        check("t3_errcnt", bus.o_Err_Count, 2);

        tx(SOF, 0); tx(8'h00, 0);
        settle("t4_timeout");
        tx_frame(8'h00, 8'h09, 8'h09);
        settle("t4_after");

        tx(8'h00, 0); tx(8'hFF, 1); tx(8'h3C, 0);
        tx_frame(SOF, 8'h03, 8'hA6);
        settle("t5");

        tx(SOF, 0); tx(8'h02, T - 1); tx(8'h0B, T - 1); tx(8'h09, T - 1);
        settle("tmo_edge_accept");
        tx(SOF, 0); tx(8'h02, 0); tx(8'h03, T); tx(8'h01, 0);
        settle("tmo_edge_reject");

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    a = addrs[$urandom_range(0, 5)]; d = 8'($urandom);
                    tx(SOF, rand_gap()); tx(a, rand_gap()); tx(d, rand_gap()); tx(a ^ d, rand_gap());
                end
                2: begin
                    a = addrs[$urandom_range(0, 5)]; d = 8'($urandom);
                    c = (a ^ d) ^ 8'($urandom_range(1, 255));
                    tx_frame(a, d, c);
                end
                3: begin
                    a = 8'($urandom); d = 8'($urandom);
                    tx_frame(a, d, a ^ d);
                end
                4: begin
                    for (int k = 0; k < $urandom_range(1, 3); k++) tx(8'($urandom), $urandom_range(0, 3));
                end
                default: begin
                    tx(SOF, 0);
                    for (int k = 0; k < $urandom_range(1, 2); k++) tx(8'($urandom), 0);
                    idle(T + 2);
                    model_byte(8'h00, T + 2);
                    send(8'h00);
                end
            endcase
            if (it % 5 == 4) settle($sformatf("rand%0d", it));
        end

        for (int i = 0; i < 300; i++) tx_frame(8'h03, 8'h04, 8'h00);
        settle("sat");
        check("sat_errcnt", bus.o_Err_Count, 8'hFF);

        tx(SOF, 0); tx(8'h01, 0);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        tx_frame(8'h00, 8'h09, 8'h09);
        settle("post_rst");
        check("post_rst_dig0", bus.o_Digits[3:0], 4'h9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
